// File: rtl/coso_link_receiver.sv
// COSO TRNG link receiver: oversamples the forwarded data clock, data and sync
// lines on clk, recovers bytes and sync-aligned 32-bit words, flags framing errors.
module coso_link_receiver #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_clk_in,
    input  logic             data_in,
    input  logic             sync_in,
    output logic [7:0]       rx_byte,
    output logic             rx_valid,
    output logic [31:0]      rx_word,
    output logic             word_valid,
    output logic             locked,
    output logic             sync_err,
    output logic             timeout_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state_q, state_d;

    logic dclk_meta_q, dclk_sync_q, dclk_dly_q;
    logic data_meta_q, data_sync_q;
    logic mark_meta_q, mark_sync_q;
    logic fall_q, bit_q, mark_q;

    logic [6:0]       shreg_q, shreg_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic [23:0]      word_q, word_d;
    logic             locked_q, locked_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_valid_q, rx_valid_d;
    logic [31:0]      rx_word_q, rx_word_d;
    logic             word_valid_q, word_valid_d;
    logic             sync_err_q, sync_err_d;
    logic             timeout_err_q, timeout_err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [7:0]       new_byte;

    // Two-flop synchronizers, then one stage that registers the detected
    // falling edge together with the mid-bit data/sync samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            dclk_meta_q <= 1'b0;
            dclk_sync_q <= 1'b0;
            dclk_dly_q  <= 1'b0;
            data_meta_q <= 1'b0;
            data_sync_q <= 1'b0;
            mark_meta_q <= 1'b0;
            mark_sync_q <= 1'b0;
            fall_q      <= 1'b0;
            bit_q       <= 1'b0;
            mark_q      <= 1'b0;
        end else begin
            dclk_meta_q <= data_clk_in;
            dclk_sync_q <= dclk_meta_q;
            dclk_dly_q  <= dclk_sync_q;
            data_meta_q <= data_in;
            data_sync_q <= data_meta_q;
            mark_meta_q <= sync_in;
            mark_sync_q <= mark_meta_q;
            fall_q      <= dclk_dly_q & ~dclk_sync_q;
            bit_q       <= data_sync_q;
            mark_q      <= mark_sync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            idx_q         <= '0;
            idle_q        <= '0;
            word_q        <= '0;
            locked_q      <= 1'b0;
            rx_byte_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_word_q     <= '0;
            word_valid_q  <= 1'b0;
            sync_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            idx_q         <= idx_d;
            idle_q        <= idle_d;
            word_q        <= word_d;
            locked_q      <= locked_d;
            rx_byte_q     <= rx_byte_d;
            rx_valid_q    <= rx_valid_d;
            rx_word_q     <= rx_word_d;
            word_valid_q  <= word_valid_d;
            sync_err_q    <= sync_err_d;
            timeout_err_q <= timeout_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign new_byte = {shreg_q, bit_q};

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        idx_d         = idx_q;
        idle_d        = idle_q;
        word_d        = word_q;
        locked_d      = locked_q;
        rx_byte_d     = rx_byte_q;
        rx_word_d     = rx_word_q;
        rx_valid_d    = 1'b0;
        word_valid_d  = 1'b0;
        sync_err_d    = 1'b0;
        timeout_err_d = 1'b0;

        if (fall_q) begin
            idle_d = '0;
            if (state_q == SHIFT && bit_cnt_q == 3'd7) begin
                state_d    = IDLE;
                bit_cnt_d  = '0;
                shreg_d    = '0;
                rx_byte_d  = new_byte;
                rx_valid_d = 1'b1;
                // Slot 3 is never stored: it goes straight into rx_word.
                case (idx_q)
                    2'd0:    word_d[23:16] = new_byte;
                    2'd1:    word_d[15:8]  = new_byte;
                    2'd2:    word_d[7:0]   = new_byte;
                    default: word_d        = word_q;
                endcase
                if (mark_q) begin
                    if (idx_q == 2'd3) begin
                        if (locked_q) begin
                            word_valid_d = 1'b1;
                            rx_word_d    = {word_q, new_byte};
                        end
                    end else begin
                        sync_err_d = 1'b1;
                        word_d     = '0;
                    end
                    idx_d    = '0;
                    locked_d = 1'b1;
                end else if (idx_q == 2'd3) begin
                    sync_err_d = locked_q;
                    locked_d   = 1'b0;
                    idx_d      = '0;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end else if (mark_q) begin
                sync_err_d = 1'b1;
                state_d    = IDLE;
                bit_cnt_d  = '0;
                shreg_d    = '0;
            end else begin
                state_d   = SHIFT;
                shreg_d   = new_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end else if (state_q == SHIFT) begin
            if (idle_q == IW'(TIMEOUT - 1)) begin
                timeout_err_d = 1'b1;
                state_d       = IDLE;
                bit_cnt_d     = '0;
                shreg_d       = '0;
                idle_d        = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end

        err_count_d = err_count_q;
        if ((sync_err_d || timeout_err_d) && err_count_q != '1) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    assign rx_byte     = rx_byte_q;
    assign rx_valid    = rx_valid_q;
    assign rx_word     = rx_word_q;
    assign word_valid  = word_valid_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;
    assign timeout_err = timeout_err_q;
    assign err_count   = err_count_q;

endmodule
